// File: rtl/md_div_sequencer_pkg.sv
// Shared encodings for the RV32M divide sequencer: op codes, FSM states and op helpers.
package md_div_sequencer_pkg;

    localparam int unsigned DIV_OP_WIDTH = 2;

    typedef enum logic [DIV_OP_WIDTH-1:0] {
        DIV_OP_DIV  = 2'd0,
        DIV_OP_DIVU = 2'd1,
        DIV_OP_REM  = 2'd2,
        DIV_OP_REMU = 2'd3
    } div_op_e;

    typedef enum logic [1:0] {
        DIV_ST_IDLE = 2'd0,
        DIV_ST_CALC = 2'd1,
        DIV_ST_FIX  = 2'd2,
        DIV_ST_DONE = 2'd3
    } div_state_e;

    function automatic logic is_signed_op(input div_op_e op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

    function automatic logic is_rem_op(input div_op_e op);
        return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    endfunction

endpackage

// File: rtl/md_div_sequencer_if.sv
// Request/response bundle between the execute stage and the divide sequencer.
interface md_div_sequencer_if
    import md_div_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    start_i;
    logic [DIV_OP_WIDTH-1:0] op_i;
    logic [DATA_WIDTH-1:0]   rs1_i;
    logic [DATA_WIDTH-1:0]   rs2_i;
    logic [4:0]              waddr_i;
    logic                    busy_o;
    logic                    done_o;
    logic [DATA_WIDTH-1:0]   result_o;
    logic [4:0]              waddr_o;

    modport master (
        output start_i, op_i, rs1_i, rs2_i, waddr_i,
        input  busy_o, done_o, result_o, waddr_o
    );

    modport slave (
        input  start_i, op_i, rs1_i, rs2_i, waddr_i,
        output busy_o, done_o, result_o, waddr_o
    );
endinterface

// File: rtl/md_div_sequencer_div_iter_step.sv
// One restoring radix-2 iteration: shift {rem, dvd} left, trial-subtract the divisor.
module div_iter_step #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rem,
    input  logic [DATA_WIDTH-1:0] dvd,
    input  logic [DATA_WIDTH-1:0] dsr,
    output logic [DATA_WIDTH-1:0] rem_nxt_c,
    output logic [DATA_WIDTH-1:0] dvd_nxt_c
);
    logic [DATA_WIDTH:0] shifted;
    logic [DATA_WIDTH:0] diff;

    // Partial remainder can reach DATA_WIDTH+1 bits after the shift.
    assign shifted = {rem, dvd[DATA_WIDTH-1]};
    assign diff    = shifted - {1'b0, dsr};

    assign rem_nxt_c = diff[DATA_WIDTH] ? shifted[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
    assign dvd_nxt_c = {dvd[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};
endmodule

// File: rtl/md_div_sequencer.sv
// Multi-cycle RV32M divide/remainder sequencer: restoring radix-2 with fast paths
// for divide-by-zero and signed overflow.
module md_div_sequencer
    import md_div_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input logic               clk,
    input logic               rst_n,
    md_div_sequencer_if.slave bus
);
    localparam logic [DATA_WIDTH-1:0] INT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ALL_ONE = '1;

    div_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    div_op_e               op_q, op_d;
    logic [4:0]            waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] dvd_q, dvd_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] dsr_q, dsr_d;
    logic                  q_neg_q, q_neg_d;
    logic                  r_neg_q, r_neg_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [4:0]            waddr_out_q, waddr_out_d;
    logic                  done_q, done_d;

    logic [DATA_WIDTH-1:0] rem_step_c;
    logic [DATA_WIDTH-1:0] dvd_step_c;

    div_op_e               req_op_c;
    logic                  req_signed_c;
    logic                  rs1_neg_c;
    logic                  rs2_neg_c;
    logic                  div_zero_c;
    logic                  overflow_c;
    logic [DATA_WIDTH-1:0] quo_fix_c;
    logic [DATA_WIDTH-1:0] rem_fix_c;

    div_iter_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
        .rem       (rem_q),
        .dvd       (dvd_q),
        .dsr       (dsr_q),
        .rem_nxt_c (rem_step_c),
        .dvd_nxt_c (dvd_step_c)
    );

    // Request decode from raw inputs, used only while IDLE.
    assign req_op_c     = div_op_e'(bus.op_i);
    assign req_signed_c = is_signed_op(req_op_c);
    assign rs1_neg_c    = req_signed_c & bus.rs1_i[DATA_WIDTH-1];
    assign rs2_neg_c    = req_signed_c & bus.rs2_i[DATA_WIDTH-1];
    assign div_zero_c   = (bus.rs2_i == '0);
    assign overflow_c   = req_signed_c & (bus.rs1_i == INT_MIN) & (bus.rs2_i == ALL_ONE);

    assign quo_fix_c = q_neg_q ? DATA_WIDTH'(-dvd_q) : dvd_q;
    assign rem_fix_c = r_neg_q ? DATA_WIDTH'(-rem_q) : rem_q;

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        waddr_d     = waddr_q;
        dvd_d       = dvd_q;
        rem_d       = rem_q;
        dsr_d       = dsr_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        result_d    = result_q;
        waddr_out_d = waddr_out_q;
        done_d      = 1'b0;

        unique case (state_q)
            DIV_ST_IDLE: begin
                if (bus.start_i) begin
                    op_d    = req_op_c;
                    waddr_d = bus.waddr_i;
                    dvd_d   = rs1_neg_c ? DATA_WIDTH'(-bus.rs1_i) : bus.rs1_i;
                    dsr_d   = rs2_neg_c ? DATA_WIDTH'(-bus.rs2_i) : bus.rs2_i;
                    rem_d   = '0;
                    q_neg_d = rs1_neg_c ^ rs2_neg_c;
                    r_neg_d = rs1_neg_c;
                    if (div_zero_c) begin
                        result_d    = is_rem_op(req_op_c) ? bus.rs1_i : ALL_ONE;
                        waddr_out_d = bus.waddr_i;
                        done_d      = 1'b1;
                        state_d     = DIV_ST_DONE;
                    end else if (overflow_c) begin
                        result_d    = is_rem_op(req_op_c) ? '0 : INT_MIN;
                        waddr_out_d = bus.waddr_i;
                        done_d      = 1'b1;
                        state_d     = DIV_ST_DONE;
                    end else begin
                        cnt_d   = CNT_WIDTH'(DATA_WIDTH - 1);
                        state_d = DIV_ST_CALC;
                    end
                end
            end
            DIV_ST_CALC: begin
                rem_d = rem_step_c;
                dvd_d = dvd_step_c;
                if (cnt_q == '0) begin
                    state_d = DIV_ST_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            DIV_ST_FIX: begin
                result_d    = is_rem_op(op_q) ? rem_fix_c : quo_fix_c;
                waddr_out_d = waddr_q;
                done_d      = 1'b1;
                state_d     = DIV_ST_DONE;
            end
            DIV_ST_DONE: begin
                state_d = DIV_ST_IDLE;
            end
            default: begin
                state_d = DIV_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= DIV_ST_IDLE;
            cnt_q       <= '0;
            op_q        <= DIV_OP_DIV;
            waddr_q     <= '0;
            dvd_q       <= '0;
            rem_q       <= '0;
            dsr_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            result_q    <= '0;
            waddr_out_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            waddr_q     <= waddr_d;
            dvd_q       <= dvd_d;
            rem_q       <= rem_d;
            dsr_q       <= dsr_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            result_q    <= result_d;
            waddr_out_q <= waddr_out_d;
            done_q      <= done_d;
        end
    end

    // Busy follows start_i combinationally so the pipeline freezes in the request cycle.
    assign bus.busy_o   = rst_n & (((state_q == DIV_ST_IDLE) & bus.start_i) |
                                   (state_q == DIV_ST_CALC) |
                                   (state_q == DIV_ST_FIX));
    assign bus.done_o   = done_q;
    assign bus.result_o = result_q;
    assign bus.waddr_o  = waddr_out_q;

endmodule

// File: tb/tb_md_div_sequencer.sv
// Directed bench for md_div_sequencer: normal and fast-path latency, sign fixup,
// ignored starts, mid-operation reset and back-to-back requests.
module tb_md_div_sequencer;
    import md_div_sequencer_pkg::*;

    localparam int unsigned W        = 32;
    localparam int          NORM_LAT = 34;
    localparam int          FAST_LAT = 1;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    md_div_sequencer_if #(.DATA_WIDTH(W)) bus ();

    md_div_sequencer #(.DATA_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic drive_req(input logic st, input div_op_e op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [4:0] wa);
        bus.start_i = st;
        bus.op_i    = op;
        bus.rs1_i   = a;
        bus.rs2_i   = b;
        bus.waddr_i = wa;
    endtask

    // Issue one request at cycle T and check busy/done across the expected latency.
    task automatic run_op(input string tag, input div_op_e op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [4:0] wa,
                          input logic [W-1:0] exp, input int lat);
        int bad;
        bad = 0;
        @(negedge clk);
        drive_req(1'b1, op, a, b, wa);
        #1;
        check({tag, "_busy_T"}, W'(bus.busy_o), W'(1));
        check({tag, "_done_T"}, W'(bus.done_o), W'(0));
        @(negedge clk);
        bus.start_i = 1'b0;
        for (int k = 1; k < lat; k++) begin
            if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b1) bad++;
            @(negedge clk);
        end
        check({tag, "_busy_window"}, W'(bad), W'(0));
        check({tag, "_done"},   W'(bus.done_o), W'(1));
        check({tag, "_busy_done"}, W'(bus.busy_o), W'(0));
        check({tag, "_result"}, bus.result_o, exp);
        check({tag, "_waddr"},  W'(bus.waddr_o), W'(wa));
    endtask

    initial begin
        int bad;
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        drive_req(1'b0, DIV_OP_DIV, '0, '0, 5'd0);
        repeat (3) @(negedge clk);
        check("rst_busy",   W'(bus.busy_o), W'(0));
        check("rst_done",   W'(bus.done_o), W'(0));
        check("rst_result", bus.result_o, '0);
        check("rst_waddr",  W'(bus.waddr_o), '0);
        rst_n = 1'b1;

        run_op("div_100_7",   DIV_OP_DIV,  32'd100,        32'd7, 5'd5,  32'd14,        NORM_LAT);
        run_op("rem_m7_2",    DIV_OP_REM,  32'hFFFF_FFF9,  32'd2, 5'd6,  32'hFFFF_FFFF, NORM_LAT);
        run_op("div_m7_2",    DIV_OP_DIV,  32'hFFFF_FFF9,  32'd2, 5'd7,  32'hFFFF_FFFD, NORM_LAT);
        run_op("divu_big_2",  DIV_OP_DIVU, 32'hFFFF_FFF9,  32'd2, 5'd8,  32'h7FFF_FFFC, NORM_LAT);
        run_op("divu_by0",    DIV_OP_DIVU, 32'd123,        32'd0, 5'd9,  32'hFFFF_FFFF, FAST_LAT);
        run_op("remu_by0",    DIV_OP_REMU, 32'd123,        32'd0, 5'd10, 32'd123,       FAST_LAT);
        run_op("div_ovf",     DIV_OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000, FAST_LAT);
        run_op("rem_ovf",     DIV_OP_REM,  32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'd0,  FAST_LAT);
        run_op("div_m20_m6",  DIV_OP_DIV,  32'hFFFF_FFEC,  32'hFFFF_FFFA, 5'd13, 32'd3, NORM_LAT);
        run_op("rem_20_m6",   DIV_OP_REM,  32'd20,         32'hFFFF_FFFA, 5'd14, 32'd2, NORM_LAT);

        // Result and address hold through IDLE.
        @(negedge clk);
        @(negedge clk);
        check("idle_hold_result", bus.result_o, 32'd2);
        check("idle_hold_waddr",  W'(bus.waddr_o), W'(14));

        // start_i toggled with other operands during CALC is ignored.
        @(negedge clk);
        drive_req(1'b1, DIV_OP_DIV, 32'd100, 32'd7, 5'd5);
        @(negedge clk);
        bad = 0;
        for (int k = 1; k < NORM_LAT; k++) begin
            if (k >= 3 && k <= 8) drive_req(k[0], DIV_OP_REMU, 32'd999, 32'd3, 5'd21);
            else bus.start_i = 1'b0;
            if (bus.done_o !== 1'b0) bad++;
            @(negedge clk);
        end
        check("ign_early_done", W'(bad), W'(0));
        check("ign_done",   W'(bus.done_o), W'(1));
        check("ign_result", bus.result_o, 32'd14);
        check("ign_waddr",  W'(bus.waddr_o), W'(5));
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done_o !== 1'b0) bad++;
        end
        check("ign_no_extra_done", W'(bad), W'(0));

        // Reset at T+10 aborts the operation without a done pulse.
        drive_req(1'b1, DIV_OP_DIVU, 32'd1000, 32'd3, 5'd17);
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy",   W'(bus.busy_o), W'(0));
        check("abort_result", bus.result_o, '0);
        check("abort_waddr",  W'(bus.waddr_o), '0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) bad++;
        end
        check("abort_no_done", W'(bad), W'(0));

        // Back-to-back: second start in the IDLE cycle right after done_o.
        run_op("b2b_remu_50_9", DIV_OP_REMU, 32'd50, 32'd9,  5'd3, 32'd5, NORM_LAT);
        run_op("b2b_remu_9_50", DIV_OP_REMU, 32'd9,  32'd50, 5'd4, 32'd9, NORM_LAT);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
